// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_arbiter
//  Description : 640x480@60 VGA scan-out from a 160x120x12 single-port
//                framebuffer with 4x pixel replication, sharing every RAM
//                slot the display does not need with one pixel writer.
//                Optional power-up auto-clear enabled by macro FB_CLEAR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter logic [9:0]  H_ACTIVE    = 10'd640,
    parameter logic [9:0]  H_TOTAL     = 10'd800,
    parameter logic [9:0]  HS_START    = 10'd660,
    parameter logic [9:0]  HS_END      = 10'd756,
    parameter logic [9:0]  V_ACTIVE    = 10'd480,
    parameter logic [9:0]  V_TOTAL     = 10'd525,
    parameter logic [9:0]  VS_START    = 10'd494,
    parameter logic [9:0]  VS_END      = 10'd495,
    parameter logic [11:0] CLEAR_COLOR = 12'hCCC
) (
    input  logic        CLOCK_50,
    input  logic        RST_N,
    input  logic        WR_REQ,
    input  logic [14:0] WR_ADDR,
    input  logic [11:0] WR_DATA,
    output logic        WR_ACK,
    output logic        WR_ERR,
    output logic        BUSY,
    output logic [14:0] MEM_ADDR,
    output logic        MEM_WE,
    output logic [11:0] MEM_WDATA,
    input  logic [11:0] MEM_RDATA,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS
);

    localparam logic [14:0] FB_WORDS = 15'd19200;
    localparam logic [14:0] FB_LAST  = 15'd19199;

    logic        r_phase;
    logic [9:0]  r_col;
    logic [9:0]  r_line;
    logic [11:0] r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_err;
    logic [14:0] r_last_addr;

    logic        w_active;
    logic        w_disp_slot;
    logic        w_wr_slot;
    logic        w_grant;
    logic        w_addr_ok;
    logic [7:0]  w_row;
    logic [7:0]  w_colw;
    logic [14:0] w_disp_addr;

    logic        w_busy;
    logic        w_clear_we;
    logic [14:0] w_clear_addr;

    assign w_active    = (r_col < H_ACTIVE) && (r_line < V_ACTIVE);
    assign w_disp_slot = !r_phase && w_active;
    assign w_wr_slot   = !w_disp_slot;
    assign w_addr_ok   = (WR_ADDR < FB_WORDS);
    assign w_grant     = RST_N && WR_REQ && !w_busy && w_wr_slot;

    // row*160 + col built from shifts: row*128 + row*32 + col
    assign w_row       = r_line[9:2];
    assign w_colw      = r_col[9:2];
    assign w_disp_addr = {w_row, 7'b0} + {2'b0, w_row, 5'b0} + {7'b0, w_colw};

`ifdef FB_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [14:0] r_clear_addr;

    // State register: reset always restarts the clear sweep
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) r_state <= ST_CLEAR;
        else        r_state <= w_state_next;
    end

    // Next state: leave CLEAR once the last framebuffer word is written
    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_CLEAR && w_clear_we && r_clear_addr == FB_LAST)
            w_state_next = ST_RUN;
    end

    // FSM outputs: clear owns every writer-eligible slot while busy
    always_comb begin
        w_busy     = (r_state == ST_CLEAR);
        w_clear_we = (r_state == ST_CLEAR) && w_wr_slot && RST_N;
    end

    // Clear address advances once per clear write
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N)          r_clear_addr <= 15'd0;
        else if (w_clear_we) r_clear_addr <= r_clear_addr + 15'd1;
    end

    assign w_clear_addr = r_clear_addr;
`else
    assign w_busy       = 1'b0;
    assign w_clear_we   = 1'b0;
    assign w_clear_addr = 15'd0;
`endif

    // Phase toggles every cycle; column/line counters advance on phase 1
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_phase <= 1'b0;
            r_col   <= 10'd0;
            r_line  <= 10'd0;
        end else begin
            r_phase <= ~r_phase;
            if (r_phase) begin
                if (r_col == H_TOTAL - 10'd1) begin
                    r_col  <= 10'd0;
                    r_line <= (r_line == V_TOTAL - 10'd1) ? 10'd0 : r_line + 10'd1;
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
        end
    end

    // Pixel capture and sync decode at the end of each pixel period
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_rgb <= 12'h000;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else if (r_phase) begin
            r_rgb <= w_active ? MEM_RDATA : 12'h000;
            r_hs  <= !((r_col >= HS_START) && (r_col <= HS_END));
            r_vs  <= !((r_line >= VS_START) && (r_line <= VS_END));
        end
    end

    // Sticky error for an acknowledged out-of-range write
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N)                      r_err <= 1'b0;
        else if (w_grant && !w_addr_ok)  r_err <= 1'b1;
    end

    // Remember the last RAM address so idle slots keep the bus quiet
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) r_last_addr <= 15'd0;
        else        r_last_addr <= MEM_ADDR;
    end

    // RAM port mux: display read, then clear write, then writer grant
    always_comb begin
        MEM_ADDR  = r_last_addr;
        MEM_WE    = 1'b0;
        MEM_WDATA = WR_DATA;
        if (w_disp_slot) begin
            MEM_ADDR = w_disp_addr;
        end else if (w_clear_we) begin
            MEM_ADDR  = w_clear_addr;
            MEM_WE    = 1'b1;
            MEM_WDATA = CLEAR_COLOR;
        end else if (w_grant) begin
            MEM_ADDR = WR_ADDR;
            MEM_WE   = w_addr_ok;
        end
    end

    assign WR_ACK = w_grant;
    assign WR_ERR = r_err;
    assign BUSY   = w_busy;
    assign VGA_R  = r_rgb[11:8];
    assign VGA_G  = r_rgb[7:4];
    assign VGA_B  = r_rgb[3:0];
    assign VGA_HS = r_hs;
    assign VGA_VS = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_fb_arbiter
//  Description : Directed self-checking bench for vga_fb_arbiter with a
//                synchronous-read framebuffer RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

`ifdef FB_CLEAR_EN
    localparam int LB = 20;
`else
    localparam int LB = 0;
`endif
    localparam int AB = (LB / 4) * 160;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic        busy;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs;

    logic [11:0] ram [0:19199];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    vga_fb_arbiter dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .WR_REQ   (wr_req),
        .WR_ADDR  (wr_addr),
        .WR_DATA  (wr_data),
        .WR_ACK   (wr_ack),
        .WR_ERR   (wr_err),
        .BUSY     (busy),
        .MEM_ADDR (mem_addr),
        .MEM_WE   (mem_we),
        .MEM_WDATA(mem_wdata),
        .MEM_RDATA(mem_rdata),
        .VGA_R    (vga_r),
        .VGA_G    (vga_g),
        .VGA_B    (vga_b),
        .VGA_HS   (vga_hs),
        .VGA_VS   (vga_vs)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, write on rising edge
    always @(posedge clk) begin
        if (mem_we && mem_addr < 15'd19200) ram[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_addr < 15'd19200) ? ram[mem_addr] : 12'h000;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    function automatic int cyc_of(input int i, input int j, input int ph);
        return ((j * 800) + i) * 2 + ph;
    endfunction

    function automatic logic [31:0] rgb();
        return {20'd0, vga_r, vga_g, vga_b};
    endfunction

`ifdef FB_CLEAR_EN
    task automatic run_clear();
        int          pulses = 0;
        int          bad    = 0;
        int          acks   = 0;
        logic [14:0] exp_a  = 15'd0;
        bit          done   = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 15'd100;
        wr_data = 12'hABC;
        for (int k = 0; k < 33000 && !done; k++) begin
            #1;
            if (!busy) done = 1'b1;
            else begin
                if (wr_ack) acks++;
                if (mem_we) begin
                    if (mem_addr !== exp_a || mem_wdata !== 12'hCCC) bad++;
                    exp_a++;
                    pulses++;
                end
                tick();
            end
        end
        chk("clear_done",       {31'd0, done}, 32'd1);
        chk("clear_pulses",     pulses,        32'd19200);
        chk("clear_bad_writes", bad,           32'd0);
        chk("clear_acks",       acks,          32'd0);
        chk("busy_fall_cycle",  cyc,           32'd32000);
    endtask
`endif

    initial begin
        int hs_low = 0;
        int vs_low = 0;
        int first_low = -1;

        for (int a = 0; a < 19200; a++) ram[a] = 12'hCCC;

        // Reset state, with a request pending
        rst_n   = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 15'd5;
        wr_data = 12'h123;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ack",  {31'd0, wr_ack}, 32'd0);
        chk("rst_we",   {31'd0, mem_we}, 32'd0);
        chk("rst_hs",   {31'd0, vga_hs}, 32'd1);
        chk("rst_vs",   {31'd0, vga_vs}, 32'd1);
        chk("rst_rgb",  rgb(),           32'd0);
        chk("rst_err",  {31'd0, wr_err}, 32'd0);
`ifdef FB_CLEAR_EN
        chk("rst_busy", {31'd0, busy},   32'd1);
`else
        chk("rst_busy", {31'd0, busy},   32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

`ifdef FB_CLEAR_EN
        run_clear();
`endif

        // Write addr AB=F00 during the active area: phase 0 is the display slot
        goto(cyc_of(0, LB, 0));
        wr_req  = 1'b1;
        wr_addr = 15'(AB);
        wr_data = 12'hF00;
        #1;
        chk("act_ph0_ack",  {31'd0, wr_ack}, 32'd0);
        chk("act_ph0_we",   {31'd0, mem_we}, 32'd0);
        chk("act_ph0_addr", mem_addr,        AB);
        tick(); #1;
        chk("act_ph1_ack",   {31'd0, wr_ack}, 32'd1);
        chk("act_ph1_we",    {31'd0, mem_we}, 32'd1);
        chk("act_ph1_addr",  mem_addr,        AB);
        chk("act_ph1_wdata", mem_wdata,       32'hF00);
        tick();
        wr_req  = 1'b0;
        wr_addr = 15'h1234;
        #1;
        chk("pix0_before_write", rgb(), 32'hCCC);

        goto(cyc_of(4, LB, 0)); #1;
        chk("pix3_after_write", rgb(), 32'hF00);
        tick(); #1;
        chk("idle_hold_addr", mem_addr,        AB + 1);
        chk("idle_we",        {31'd0, mem_we}, 32'd0);
        chk("idle_ack",       {31'd0, wr_ack}, 32'd0);

        // Back-to-back writes in horizontal blank: acked every cycle
        goto(cyc_of(640, LB, 0));
        wr_req = 1'b1; wr_addr = 15'(AB + 1); wr_data = 12'h0F0; #1;
        chk("hb0_ack",  {31'd0, wr_ack}, 32'd1);
        chk("hb0_we",   {31'd0, mem_we}, 32'd1);
        chk("hb0_addr", mem_addr,        AB + 1);
        tick();
        wr_addr = 15'(AB + 2); wr_data = 12'h00F; #1;
        chk("hb1_ack",   {31'd0, wr_ack}, 32'd1);
        chk("hb1_addr",  mem_addr,        AB + 2);
        chk("hb1_wdata", mem_wdata,       32'h00F);
        tick();
        wr_addr = 15'(AB + 3); wr_data = 12'h555; #1;
        chk("hb2_ack",  {31'd0, wr_ack}, 32'd1);
        chk("hb2_we",   {31'd0, mem_we}, 32'd1);
        tick();
        wr_req = 1'b0;

        // Next line shows the written pixels with 4x replication
        goto(cyc_of(1, LB + 1, 0));  #1; chk("l1_pix0",   rgb(), 32'hF00);
        goto(cyc_of(6, LB + 1, 0));  #1; chk("l1_pix5",   rgb(), 32'h0F0);
        goto(cyc_of(11, LB + 1, 0)); #1; chk("l1_pix10",  rgb(), 32'h00F);
        goto(cyc_of(14, LB + 1, 0)); #1; chk("l1_pix13",  rgb(), 32'h555);
        goto(cyc_of(17, LB + 1, 0)); #1; chk("l1_pix16",  rgb(), 32'hCCC);
        goto(cyc_of(640, LB + 1, 0)); #1; chk("l1_pix639", rgb(), 32'hCCC);
        goto(cyc_of(641, LB + 1, 0)); #1; chk("l1_pix640", rgb(), 32'h000);
        goto(cyc_of(701, LB + 1, 0)); #1; chk("l1_pix700", rgb(), 32'h000);

        // Out-of-range write: acked, not written, sticky error
        goto(cyc_of(650, LB + 2, 0));
        wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 12'hFFF; #1;
        chk("oor_ack", {31'd0, wr_ack}, 32'd1);
        chk("oor_we",  {31'd0, mem_we}, 32'd0);
        tick();
        wr_req = 1'b0; #1;
        chk("oor_err", {31'd0, wr_err}, 32'd1);

        // One full line of sync: HS low 194 cycles starting at offset 1322
        goto(cyc_of(0, LB + 3, 0));
        for (int k = 0; k < 1600; k++) begin
            #1;
            if (!vga_hs) begin
                hs_low++;
                if (first_low < 0) first_low = k;
            end
            if (!vga_vs) vs_low++;
            tick();
        end
        chk("hs_low_cycles", hs_low,    32'd194);
        chk("hs_first_low",  first_low, 32'd1322);
        chk("vs_low_cycles", vs_low,    32'd0);

        // Display address for (i=20, j=LB+5): row LB/4+1, column 5
        goto(cyc_of(20, LB + 5, 0)); #1;
        chk("disp_addr", mem_addr,        AB + 165);
        chk("disp_we",   {31'd0, mem_we}, 32'd0);

        goto(cyc_of(0, LB + 6, 0)); #1;
        chk("err_sticky", {31'd0, wr_err}, 32'd1);

        // Asynchronous reset mid-line
        goto(cyc_of(100, LB + 7, 1));
        wr_req = 1'b1; wr_addr = 15'd7; wr_data = 12'h321; #1;
        chk("pre_rst_ack", {31'd0, wr_ack}, 32'd1);
        chk("pre_rst_rgb", rgb(),           32'hCCC);
        rst_n = 1'b0; #1;
        chk("mid_rst_ack", {31'd0, wr_ack}, 32'd0);
        chk("mid_rst_we",  {31'd0, mem_we}, 32'd0);
        chk("mid_rst_rgb", rgb(),           32'd0);
        chk("mid_rst_err", {31'd0, wr_err}, 32'd0);
        chk("mid_rst_hs",  {31'd0, vga_hs}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
`ifdef FB_CLEAR_EN
        run_clear();
`else
        #1;
        chk("rerst_addr", mem_addr,        32'd0);
        chk("rerst_ack0", {31'd0, wr_ack}, 32'd0);
        tick(); #1;
        chk("rerst_ack1", {31'd0, wr_ack}, 32'd1);
        chk("rerst_we1",  {31'd0, mem_we}, 32'd1);
        chk("rerst_a1",   mem_addr,        32'd7);
`endif
        wr_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Display controller that shares a single-port 160x120x12-bit framebuffer RAM between VGA scan-out and one pixel-writer requester. It generates 640x480@60 timing from CLOCK_50 and reads the framebuffer with 4x pixel replication. It grants the writer every RAM slot the display does not need, and drives VGA_R/G/B/HS/VS directly. It sits between the drawing logic (writer) and the VGA pins, and is the only master of the framebuffer RAM.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixel periods per line
- HS_START / HS_END, 660 / 756, HS low when delayed column in [HS_START, HS_END] inclusive
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, lines per frame
- VS_START / VS_END, 494 / 495, VS low when delayed line in [VS_START, VS_END] inclusive
- CLEAR_COLOR, 12'hCCC, fill value used by auto-clear ({R,G,B})
- CLOCK_50  in  1  system clock, 50 MHz; all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- WR_REQ  in  1  writer request; held until WR_ACK seen
- WR_ADDR  in  15  framebuffer word address, row*160+col; stable while WR_REQ
- WR_DATA  in  12  pixel {R[11:8],G[7:4],B[3:0]}; stable while WR_REQ
- WR_ACK  out  1  grant; write completes at the rising edge where WR_ACK=1
- WR_ERR  out  1  sticky: an acked WR_ADDR was >= 19200
- BUSY  out  1  auto-clear in progress; writer is not served
- MEM_ADDR  out  15  RAM address
- MEM_WE  out  1  RAM write enable
- MEM_WDATA  out  12  RAM write data
- MEM_RDATA  in  12  RAM read data, valid one cycle after MEM_ADDR
- VGA_R, VGA_G, VGA_B  out  4 each  colour
- VGA_HS, VGA_VS  out  1 each  sync, active low

## Operation
- Phase bit toggles every CLOCK_50 cycle. Phase 0 is the display slot and phase 1 is the writer slot. One pixel period is 2 cycles.
- Column counter i (0..799) advances on phase 1. At wrap, line counter j (0..524) advances. j wraps 524→0.
- Phase 0 with i<640, j<480: MEM_ADDR=(j>>2)*160+(i>>2), computed as shifts/adds; MEM_WE=0.
- Writer grant: phase 1 always. Phase 0 only outside the active area.
- A grant is issued when WR_REQ=1 and BUSY=0. WR_ACK, MEM_ADDR, MEM_WE and MEM_WDATA are combinational from registered state and the WR_* inputs.
- WR_ADDR>=19200: WR_ACK=1, MEM_WE=0, WR_ERR set. WR_ERR is cleared only by reset.
- Pixel capture (end of phase 1):
  - Active area: RGB registers load MEM_RDATA.
  - Otherwise: RGB registers load 0.
- HS/VS registers load their decode of the current (i,j) on the same edge.
- Unused slots (phase 0 active with no writer, or no request): MEM_WE=0, MEM_ADDR holds the last value.
- Reset values:
  - Counters 0, phase 0.
  - VGA_R/G/B=0, VGA_HS=1, VGA_VS=1.
  - WR_ERR=0.
  - WR_ACK=0 and MEM_WE=0 while RST_N low.
  - BUSY=1 if FB_CLEAR_EN is defined, else 0.
- Reset mid-operation aborts everything; no partial-write guarantee for the cycle in which RST_N falls.

## Timing
- VGA pins lag the counters by exactly one pixel period. Colour and sync stay mutually aligned.
- HS low 97 pixel periods (194 cycles) every 1600 cycles. VS low 2 lines (3200 cycles) every 840000 cycles.
- Active line: 640 writer slots (phase 1) plus 320 slots in horizontal blank, i.e. 960 per line. Blank lines: 1600 slots.
- Writer latency from WR_REQ rise (BUSY=0):
  - Active area: ≤1 cycle.
  - Blanking: 0 cycles.
- Back-to-back requests in blanking are acked on consecutive cycles.
- Written pixel visible from the next scan of that location. No tearing protection.

## Configuration
- FB_CLEAR_EN defined: two-state FSM CLEAR→RUN.
  - CLEAR: 15-bit clear address runs 0..19199. It writes CLEAR_COLOR in every writer-eligible slot, in ascending order.
  - BUSY=1 and WR_ACK=0 throughout CLEAR.
  - After the write to 19199 the FSM enters RUN and BUSY=0 from the next cycle.
  - Starting from reset at (0,0), the 19200 writes fill lines 0..19 exactly, so BUSY falls when counters reach (i=0, j=20).
- FB_CLEAR_EN undefined: no FSM. BUSY tied 0. Writer is served from the first slot after reset. RAM content is undefined until written.

## Test plan
- Reset, then free-run one frame → VGA_HS low 194 cycles per 1600, VGA_VS low 3200 cycles per 840000, RGB=0 outside visible area.
- FB_CLEAR_EN, release reset → exactly 19200 MEM_WE pulses, data 0xCCC, addresses 0..19199 ascending; BUSY falls at (0,20); WR_REQ held meanwhile gets no WR_ACK.
- After clear, write addr 0 data 0xF00 during active area → WR_ACK only on a phase-1 cycle; next frame, pixels x0..3, y0..3 show R=F, G=0, B=0; neighbours show C,C,C.
- WR_REQ held continuously, address incrementing, during vertical blank → WR_ACK=1 every cycle, one write per cycle.
- WR_ADDR=19200, data 0xFFF → single WR_ACK, MEM_WE=0, WR_ERR=1 and stays 1 until reset.
- RST_N pulsed low at line 10 of clear → outputs return to reset values immediately; clear restarts at address 0; BUSY falls at (0,20) again.
